// File: rtl/s7_align_pkg.sv
// rtl/s7_align_pkg.sv - shared state type, default frame pattern and slip counter width
package s7_align_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SLIP,
      ST_SETTLE,
      ST_LOCKED,
      ST_FAIL
   } state_t;

   localparam logic [7:0] DEFAULT_PATTERN = 8'hF0;

   // slip_cnt must hold 0..DW inclusive
   function automatic int slip_cnt_w(input int dw);
      return $clog2(dw) + 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
   parameter int          W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // clear wins over increment; the count holds at MAX instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/s7_frame_align.sv
// rtl/s7_frame_align.sv - frame-lane word aligner driving ISERDES bitslip; FRAME_ALIGN_STATS_EN adds lock_loss_cnt/total_slips
module s7_frame_align
   import s7_align_pkg::*;
#(
   parameter int            DW       = 8,
   parameter logic [DW-1:0] PATTERN  = DW'(DEFAULT_PATTERN),
   parameter int            SETTLE   = 4,
   parameter int            LOCK_CNT = 16,
   parameter int            LOSS_CNT = 4
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        enable,
   input  logic [DW-1:0]               data_in,
   input  logic                        data_valid,
   output logic                        bitslip,
   output logic                        locked,
   output logic                        align_fail,
   output logic [slip_cnt_w(DW)-1:0]   slip_cnt
`ifdef FRAME_ALIGN_STATS_EN
   ,
   output logic [15:0]                 lock_loss_cnt,
   output logic [15:0]                 total_slips
`endif
);

   localparam int SW = slip_cnt_w(DW);
   localparam int RW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);
   localparam int TW = $clog2(SETTLE + 1);

   localparam logic [RW-1:0] RUN_LAST    = RW'(LOCK_CNT - 1);
   localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CNT - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
   localparam logic [SW-1:0] SLIP_MAX    = SW'(DW);

   state_t        state;
   state_t        next_state;
   logic [RW-1:0] run_cnt;
   logic [LW-1:0] loss_cnt;
   logic [TW-1:0] settle_cnt;

   logic good_word;
   logic bad_word;

   assign good_word = data_valid && (data_in == PATTERN);
   assign bad_word  = data_valid && (data_in != PATTERN);

   // next-state decision; enable low overrides everything and returns to IDLE
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   next_state = ST_CHECK;
         ST_CHECK: begin
            if (good_word && (run_cnt == RUN_LAST)) begin
               next_state = ST_LOCKED;
            end else if (bad_word) begin
               next_state = (slip_cnt < SLIP_MAX) ? ST_SLIP : ST_FAIL;
            end
         end
         ST_SLIP:   next_state = ST_SETTLE;
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               next_state = ST_CHECK;
            end
         end
         ST_LOCKED: begin
            if (bad_word && (loss_cnt == LOSS_LAST)) begin
               next_state = ST_CHECK;
            end
         end
         ST_FAIL:   next_state = ST_FAIL;
         default:   next_state = ST_IDLE;
      endcase
      if (!enable) begin
         next_state = ST_IDLE;
      end
   end

   // state register and registered outputs derived from the upcoming state
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         bitslip    <= 1'b0;
         locked     <= 1'b0;
         align_fail <= 1'b0;
      end else begin
         state      <= next_state;
         bitslip    <= (next_state == ST_SLIP);
         locked     <= (next_state == ST_LOCKED);
         align_fail <= (next_state == ST_FAIL);
      end
   end

   // consecutive matching words while searching; restarts whenever CHECK is left
   sat_counter #(.W(RW)) u_run (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (next_state != ST_CHECK),
      .inc   ((state == ST_CHECK) && good_word),
      .count (run_cnt)
   );

   // consecutive mismatches while locked; any valid match forgives them
   sat_counter #(.W(LW)) u_loss (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   ((next_state != ST_LOCKED) || ((state == ST_LOCKED) && good_word)),
      .inc   ((state == ST_LOCKED) && bad_word),
      .count (loss_cnt)
   );

   // pipeline flush timer, runs on every cycle spent in SETTLE
   sat_counter #(.W(TW)) u_settle (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (state != ST_SETTLE),
      .inc   (state == ST_SETTLE),
      .count (settle_cnt)
   );

   // slips in this attempt; survives lock loss so the search resumes from the current phase
   sat_counter #(.W(SW), .MAX(SLIP_MAX)) u_slip (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (next_state == ST_IDLE),
      .inc   (next_state == ST_SLIP),
      .count (slip_cnt)
   );

`ifdef FRAME_ALIGN_STATS_EN
   // lifetime statistics, cleared only by reset
   sat_counter #(.W(16)) u_stat_loss (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (1'b0),
      .inc   ((state == ST_LOCKED) && (next_state == ST_CHECK)),
      .count (lock_loss_cnt)
   );

   sat_counter #(.W(16)) u_stat_slip (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (1'b0),
      .inc   (next_state == ST_SLIP),
      .count (total_slips)
   );
`endif

endmodule

// File: tb/tb_s7_frame_align.sv
// tb/tb_s7_frame_align.sv - bench for s7_frame_align with a rotating-lane ISERDES model
module tb_s7_frame_align;

   localparam int         DW       = 8;
   localparam logic [7:0] PAT      = 8'hF0;
   localparam int         SETTLE   = 4;
   localparam int         LOCK_CNT = 16;
   localparam int         LOSS_CNT = 4;
   localparam int         SW       = $clog2(DW) + 1;
   localparam int         SLOT     = 2 + SETTLE;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          enable;
   logic [7:0]    data_in;
   logic          data_valid;
   logic          bitslip;
   logic          locked;
   logic          align_fail;
   logic [SW-1:0] slip_cnt;
`ifdef FRAME_ALIGN_STATS_EN
   logic [15:0]   lock_loss_cnt;
   logic [15:0]   total_slips;
`endif

   int total = 0;
   int bad   = 0;

   int         mode;
   int         lane_rot;
   logic [7:0] const_word;
   int         cyc;
   int         pulses;

   s7_frame_align dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .enable     (enable),
      .data_in    (data_in),
      .data_valid (data_valid),
      .bitslip    (bitslip),
      .locked     (locked),
      .align_fail (align_fail),
      .slip_cnt   (slip_cnt)
`ifdef FRAME_ALIGN_STATS_EN
      ,
      .lock_loss_cnt (lock_loss_cnt),
      .total_slips   (total_slips)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
      logic [7:0] r;
      int         k;
      r = w;
      k = ((n % 8) + 8) % 8;
      for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] other_word();
      logic [7:0] w;
      w = 8'($urandom);
      if (w == PAT) w = ~w;
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock: drive the lane word, sample #1 after the edge, let the lane react to bitslip
   task automatic step();
      if (mode == 0) data_in = rotl(PAT, lane_rot);
      else if (mode == 1) data_in = const_word;
      @(posedge sys_clk);
      #1;
      cyc++;
      if (bitslip === 1'b1) begin
         pulses++;
         lane_rot++;
      end
   endtask

   task automatic run_to_lock(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget && at < 0; i++) begin
         step();
         if (locked === 1'b1) at = cyc;
      end
   endtask

   initial begin
      int   at;
      int   exp_at;
      int   nvalid;
      int   prev;
      int   gap_ok;
      int   r;
      bit   v;

      sys_rst = 1'b1; enable = 1'b1; data_valid = 1'b0; data_in = 8'h00;
      mode = 2; lane_rot = 0; const_word = 8'h00; cyc = 0; pulses = 0;
      repeat (3) step();
      check("rst_bitslip", bitslip, 0);
      check("rst_locked", locked, 0);
      check("rst_align_fail", align_fail, 0);
      check("rst_slip_cnt", slip_cnt, 0);
      sys_rst = 1'b0; enable = 1'b0;
      step();

      // lock, survive 3 mismatches, then lose lock on 4 in a row and relock
      mode = 0; lane_rot = 0; data_valid = 1'b1; enable = 1'b1; cyc = 0; pulses = 0;
      run_to_lock(60, at);
      check("loss_first_lock", at, 1 + LOCK_CNT);
      mode = 2;
      for (int k = 0; k < LOSS_CNT - 1; k++) begin
         data_in = other_word();
         step();
         check("loss_hold_mismatch", locked, 1);
      end
      data_in = PAT;
      step();
      check("loss_hold_match", locked, 1);
      for (int k = 0; k < LOSS_CNT; k++) begin
         data_in = other_word();
         step();
         check("loss_drop", locked, (k < LOSS_CNT - 1) ? 1 : 0);
      end
      mode = 0; cyc = 0;
      run_to_lock(60, at);
      check("loss_relock_cycle", at, LOCK_CNT);
      check("loss_pulses", pulses, 0);
      check("loss_slip_cnt", slip_cnt, 0);
`ifdef FRAME_ALIGN_STATS_EN
      check("stat_lock_loss", lock_loss_cnt, 1);
      check("stat_total_slips", total_slips, 0);
`endif

      // lane starts rotated by r bits; each bitslip rotates it one bit towards PAT
      for (int t = 0; t < 6; t++) begin
         r = (t == 0) ? 3 : (t == 1) ? 0 : int'($urandom_range(0, 7));
         enable = 1'b0;
         step();
         check("idle_locked", locked, 0);
         check("idle_slip_cnt", slip_cnt, 0);
         mode = 0; lane_rot = -r; data_valid = 1'b1; enable = 1'b1;
         cyc = 0; pulses = 0; prev = -1; gap_ok = 1; at = -1;
         for (int i = 0; i < 300 && at < 0; i++) begin
            step();
            if (bitslip === 1'b1) begin
               if (prev >= 0 && (cyc - prev) != SLOT) gap_ok = 0;
               prev = cyc;
            end
            if (locked === 1'b1) at = cyc;
         end
         check("rot_lock_cycle", at, 1 + r * SLOT + LOCK_CNT);
         check("rot_pulses", pulses, r);
         check("rot_slip_cnt", slip_cnt, r);
         check("rot_pulse_gap", gap_ok, 1);
      end

      // data_valid gating: only valid words count, invalid mismatches ignored
      for (int t = 0; t < 3; t++) begin
         enable = 1'b0;
         step();
         mode = 2; enable = 1'b1; cyc = 0; pulses = 0; nvalid = 0; exp_at = -1; at = -1;
         for (int i = 0; i < 300 && at < 0; i++) begin
            v = (t == 0) ? ((i % 2) == 1) : ($urandom_range(0, 1) == 1);
            data_valid = v;
            data_in = v ? PAT : other_word();
            step();
            if (cyc >= 2 && v) begin
               nvalid++;
               if (nvalid == LOCK_CNT) exp_at = cyc;
            end
            if (locked === 1'b1) at = cyc;
         end
         check("gate_lock_cycle", at, exp_at);
         check("gate_pulses", pulses, 0);
      end
      data_valid = 1'b1;

      // never matches: full rotation, then fail and hold
      enable = 1'b0;
      step();
      mode = 1; const_word = 8'hAA; enable = 1'b1; cyc = 0; pulses = 0; at = -1;
      for (int i = 0; i < 200 && at < 0; i++) begin
         step();
         if (align_fail === 1'b1) at = cyc;
      end
      check("fail_cycle", at, 1 + DW * SLOT + 1);
      check("fail_pulses", pulses, DW);
      check("fail_slip_cnt", slip_cnt, DW);
      check("fail_locked", locked, 0);
      repeat (10) step();
      check("fail_hold", align_fail, 1);
      check("fail_no_more_slips", pulses, DW);
      check("fail_slip_sat", slip_cnt, DW);
      enable = 1'b0;
      step();
      check("fail_clear", align_fail, 0);
      check("fail_clear_slip_cnt", slip_cnt, 0);
      enable = 1'b1;
      step();
      step();
      check("restart_bitslip", bitslip, 1);
      check("restart_slip_cnt", slip_cnt, 1);

      // reset during SETTLE, then again while LOCKED
      enable = 1'b0;
      step();
      mode = 0; lane_rot = -3; enable = 1'b1; pulses = 0; at = -1;
      for (int i = 0; i < 20 && at < 0; i++) begin
         step();
         if (bitslip === 1'b1) at = cyc;
      end
      check("settle_slip_seen", pulses, 1);
      step();
      step();
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      check("settle_rst_bitslip", bitslip, 0);
      check("settle_rst_locked", locked, 0);
      check("settle_rst_slip_cnt", slip_cnt, 0);
      check("settle_rst_align_fail", align_fail, 0);
`ifdef FRAME_ALIGN_STATS_EN
      check("settle_rst_stat_loss", lock_loss_cnt, 0);
      check("settle_rst_stat_slips", total_slips, 0);
`endif
      pulses = 0;
      run_to_lock(100, at);
      check("post_rst_locked", locked, 1);
      check("post_rst_slip_cnt", slip_cnt, 2);
      check("post_rst_pulses", pulses, 2);
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      check("lock_rst_locked", locked, 0);
      check("lock_rst_slip_cnt", slip_cnt, 0);
      check("lock_rst_bitslip", bitslip, 0);
`ifdef FRAME_ALIGN_STATS_EN
      check("lock_rst_stat_slips", total_slips, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
